// File: rtl/ui_pkg.sv
// Shared encodings for the telephony call/menu controller: call states,
// command codes, menu indices and the wrapping menu-step helper.
package ui_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INCOMING  = 3'd1,
        ST_INITIATE  = 3'd2,
        ST_BUSY      = 3'd3,
        ST_CALL_WAIT = 3'd4
    } call_state_e;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_DIAL   = 3'd1,
        CMD_ANSWER = 3'd2,
        CMD_REJECT = 3'd3,
        CMD_HANGUP = 3'd4,
        CMD_SWAP   = 3'd5,
        CMD_SELECT = 3'd6
    } cmd_e;

    localparam logic [4:0] MENU_CALL_NUMBER = 5'd3;
    localparam logic [4:0] MENU_ADD_BLOCK   = 5'd12;

    // Up wins over down; both ends wrap around the menu.
    function automatic logic [4:0] menu_step(input logic [4:0] cur, input logic up,
                                             input logic down, input int unsigned items);
        logic [4:0] last;
        last = 5'(items - 1);
        if (up)
            return (cur == last) ? 5'd0 : cur + 5'd1;
        if (down)
            return (cur == 5'd0) ? last : cur - 5'd1;
        return cur;
    endfunction

endpackage

// File: rtl/ui_digit_buffer.sv
// Dialled-address buffer: newest digit enters the least significant nibble,
// backspace shifts it back out. Clear wins over append, append over backspace.
module ui_digit_buffer #(
    parameter int NUM_DIGITS = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              append,
    input  logic                              backspace,
    input  logic                              clear,
    input  logic [3:0]                        digit,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count
);

    localparam int AW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    // NOTE: registers take non-blocking (<=) assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits <= '0;
            count  <= '0;
        end else if (clear) begin
            digits <= '0;
            count  <= '0;
        end else if (append && digit <= 4'd9 && count < CW'(NUM_DIGITS)) begin
            digits <= {digits[AW-5:0], digit};
            count  <= count + CW'(1);
        end else if (backspace && count != '0) begin
            digits <= {4'd0, digits[AW-1:4]};
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/call_ui_ctrl.sv
// Call-state FSM, menu cursor and network command handshake for the phone UI.
// Optional caller block list is compiled in with `define CALL_BLOCK_EN.
module call_ui_ctrl
    import ui_pkg::*;
#(
    parameter int NUM_DIGITS   = 10,
    parameter int MENU_ITEMS   = 17,
    parameter int RING_TIMEOUT = 50_000_000,
    parameter int BLOCK_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              btn_enter,
    input  logic                              btn_up,
    input  logic                              btn_down,
    input  logic                              btn_left,
    input  logic                              btn_right,
    input  logic [3:0]                        digit_in,
    input  logic                              net_incoming,
    input  logic                              net_accepted,
    input  logic                              net_hangup,
    input  logic [4*NUM_DIGITS-1:0]           caller_addr,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output logic [2:0]                        cmd,
    output logic [4*NUM_DIGITS-1:0]           cmd_addr,
    output logic [2:0]                        call_state,
    output logic [4:0]                        menu_item,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

    localparam int AW = 4 * NUM_DIGITS;
    localparam int RW = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;

    call_state_e     state;
    cmd_e            cmd_q;
    logic [RW-1:0]   ring_cnt;
    logic [AW-1:0]   digits;
    logic            cmd_free, timeout, ring_state, on_dial_item;
    logic            caller_blocked, block_store, block_item, buf_clear;

    assign call_state   = state;
    assign cmd          = cmd_q;
    assign cmd_free     = !cmd_valid;
    assign timeout      = (ring_cnt == RW'(RING_TIMEOUT - 1));
    assign ring_state   = (state == ST_INCOMING) || (state == ST_INITIATE) || (state == ST_CALL_WAIT);
    assign on_dial_item = (state == ST_IDLE) && !net_incoming && (menu_item == MENU_CALL_NUMBER);
    // The dialled number stays in the buffer until the network takes the DIAL.
    assign buf_clear    = (cmd_valid && cmd_ready && cmd_q == CMD_DIAL) || block_store;

    ui_digit_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_digits (
        .clk       (clk),
        .reset_n   (reset_n),
        .append    (on_dial_item && btn_right),
        .backspace (on_dial_item && btn_left),
        .clear     (buf_clear),
        .digit     (digit_in),
        .digits    (digits),
        .count     (digit_count)
    );

`ifdef CALL_BLOCK_EN
    localparam int PW = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1;

    logic [AW-1:0]          block_addr [BLOCK_DEPTH];
    logic [BLOCK_DEPTH-1:0] block_valid;
    logic [PW-1:0]          block_ptr;

    assign block_item  = (menu_item == MENU_ADD_BLOCK);
    assign block_store = (state == ST_IDLE) && !net_incoming && btn_enter && block_item
                         && (digit_count != '0);

    always_comb begin
        // NOTE: default first so no path leaves the output unassigned (no latch).
        caller_blocked = 1'b0;
        for (int i = 0; i < BLOCK_DEPTH; i++)
            if (block_valid[i] && block_addr[i] == caller_addr)
                caller_blocked = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the list feeds a combinational match, so it is reset to keep
            // power-up garbage from ever rejecting a caller.
            for (int i = 0; i < BLOCK_DEPTH; i++)
                block_addr[i] <= '0;
            block_valid <= '0;
            block_ptr   <= '0;
        end else if (block_store) begin
            block_addr[block_ptr]  <= digits;
            block_valid[block_ptr] <= 1'b1;
            block_ptr <= (block_ptr == PW'(BLOCK_DEPTH - 1)) ? '0 : block_ptr + PW'(1);
        end
    end
`else
    localparam int unused_block_depth = BLOCK_DEPTH;
    logic unused_caller;
    assign unused_caller  = ^caller_addr;
    assign caller_blocked = 1'b0;
    assign block_store    = 1'b0;
    assign block_item     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            menu_item <= '0;
            cmd_valid <= 1'b0;
            cmd_q     <= CMD_NONE;
            cmd_addr  <= '0;
            ring_cnt  <= '0;
        end else begin
            // Slot returns to all-zero after acceptance, so issuers only set what differs.
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                cmd_q     <= CMD_NONE;
                cmd_addr  <= '0;
            end
            if (ring_state && !timeout)
                ring_cnt <= ring_cnt + RW'(1);

            case (state)
                ST_IDLE: begin
                    if (net_incoming) begin
                        if (caller_blocked) begin
                            if (cmd_free) begin cmd_valid <= 1'b1; cmd_q <= CMD_REJECT; end
                        end else begin
                            state    <= ST_INCOMING;
                            ring_cnt <= '0;
                        end
                    end else begin
                        menu_item <= menu_step(menu_item, btn_up, btn_down, MENU_ITEMS);
                        if (btn_enter && cmd_free) begin
                            if (menu_item == MENU_CALL_NUMBER) begin
                                if (digit_count != '0) begin
                                    cmd_valid <= 1'b1;
                                    cmd_q     <= CMD_DIAL;
                                    cmd_addr  <= digits;
                                    state     <= ST_INITIATE;
                                    ring_cnt  <= '0;
                                end
                            end else if (!block_item) begin
                                cmd_valid <= 1'b1;
                                cmd_q     <= CMD_SELECT;
                                cmd_addr  <= AW'(menu_item);
                            end
                        end
                    end
                end
                ST_INCOMING: begin
                    if (net_hangup)
                        state <= ST_IDLE;
                    else if (btn_enter && cmd_free) begin
                        cmd_valid <= 1'b1; cmd_q <= CMD_ANSWER; state <= ST_BUSY;
                    end else if ((btn_left || timeout) && cmd_free) begin
                        cmd_valid <= 1'b1; cmd_q <= CMD_REJECT; state <= ST_IDLE;
                    end
                end
                ST_INITIATE: begin
                    if (net_hangup)
                        state <= ST_IDLE;
                    else if (net_accepted)
                        state <= ST_BUSY;
                    else if ((btn_left || timeout) && cmd_free) begin
                        cmd_valid <= 1'b1; cmd_q <= CMD_HANGUP; state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (net_hangup)
                        state <= ST_IDLE;
                    else if (net_incoming) begin
                        if (caller_blocked) begin
                            if (cmd_free) begin cmd_valid <= 1'b1; cmd_q <= CMD_REJECT; end
                        end else begin
                            state    <= ST_CALL_WAIT;
                            ring_cnt <= '0;
                        end
                    end else begin
                        menu_item <= menu_step(menu_item, btn_up, btn_down, MENU_ITEMS);
                        if (btn_left && cmd_free) begin
                            cmd_valid <= 1'b1; cmd_q <= CMD_HANGUP; state <= ST_IDLE;
                        end else if (btn_enter && cmd_free) begin
                            cmd_valid <= 1'b1;
                            cmd_q     <= CMD_SELECT;
                            cmd_addr  <= AW'(menu_item);
                        end
                    end
                end
                ST_CALL_WAIT: begin
                    // The waiting caller keeps its original ring deadline.
                    if (net_hangup)
                        state <= ST_INCOMING;
                    else if (btn_enter && cmd_free) begin
                        cmd_valid <= 1'b1; cmd_q <= CMD_SWAP; state <= ST_BUSY;
                    end else if ((btn_left || timeout) && cmd_free) begin
                        cmd_valid <= 1'b1; cmd_q <= CMD_REJECT; state <= ST_BUSY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_ui_ctrl.sv
// Scoreboard bench for call_ui_ctrl: stimulus queues expected commands, a
// negedge monitor pops and compares each accepted command.
module tb_call_ui_ctrl;
    import ui_pkg::*;

    localparam int ND = 10;
    localparam int AW = 4 * ND;
    localparam int RT = 16;

    localparam logic [4:0] B_ENTER = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;
    localparam logic [2:0] N_INC   = 3'b100;
    localparam logic [2:0] N_ACC   = 3'b010;
    localparam logic [2:0] N_HUP   = 3'b001;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          btn_enter, btn_up, btn_down, btn_left, btn_right;
    logic [3:0]    digit_in;
    logic          net_incoming, net_accepted, net_hangup;
    logic [AW-1:0] caller_addr;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    call_state;
    logic [4:0]    menu_item;
    logic [3:0]    digit_count;

    typedef struct {
        logic [2:0]    code;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    call_ui_ctrl #(.NUM_DIGITS(ND), .MENU_ITEMS(17), .RING_TIMEOUT(RT), .BLOCK_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_enter    (btn_enter),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .digit_in     (digit_in),
        .net_incoming (net_incoming),
        .net_accepted (net_accepted),
        .net_hangup   (net_hangup),
        .caller_addr  (caller_addr),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .cmd_addr     (cmd_addr),
        .call_state   (call_state),
        .menu_item    (menu_item),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_cmd: got cmd %0d addr 0x%0h, want none", cmd, cmd_addr);
            end else begin
                e = exp_q.pop_front();
                check("cmd_code", 64'(cmd), 64'(e.code));
                check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input logic [2:0] code, input logic [AW-1:0] addr);
        exp_q.push_back('{code, addr});
    endtask

    task automatic press(input logic [4:0] b);
        {btn_enter, btn_up, btn_down, btn_left, btn_right} = b;
        cyc();
        {btn_enter, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    task automatic net(input logic [2:0] n);
        {net_incoming, net_accepted, net_hangup} = n;
        cyc();
        {net_incoming, net_accepted, net_hangup} = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && cmd_valid; i++)
            cyc();
        check("cmd_drained", 64'(cmd_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset_n = 1'b0;
        {btn_enter, btn_up, btn_down, btn_left, btn_right} = '0;
        {net_incoming, net_accepted, net_hangup} = '0;
        digit_in    = 4'd0;
        caller_addr = '0;
        cmd_ready   = 1'b1;
        #12;
        check("rst_state", 64'(call_state), 64'(ST_IDLE));
        check("rst_menu", 64'(menu_item), 64'd0);
        check("rst_count", 64'(digit_count), 64'd0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd", 64'(cmd), 64'(CMD_NONE));
        check("rst_addr", 64'(cmd_addr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // Menu wrap in both directions.
        repeat (17) press(B_UP);
        check("menu_wrap_up", 64'(menu_item), 64'd0);
        press(B_DOWN);
        check("menu_wrap_down", 64'(menu_item), 64'd16);
        press(B_UP);
        check("menu_back0", 64'(menu_item), 64'd0);
        repeat (3) press(B_UP);
        check("menu_call_number", 64'(menu_item), 64'd3);

        // Digit entry, backspace, non-BCD rejection, then DIAL under back-pressure.
        digit_in = 4'd5;
        repeat (3) press(B_RIGHT);
        digit_in = 4'd1;
        press(B_RIGHT);
        digit_in = 4'd2;
        press(B_RIGHT);
        check("count_5", 64'(digit_count), 64'd5);
        press(B_LEFT);
        check("count_backspace", 64'(digit_count), 64'd4);
        digit_in = 4'd10;
        press(B_RIGHT);
        check("count_non_bcd", 64'(digit_count), 64'd4);

        cmd_ready = 1'b0;
        expect_cmd(CMD_DIAL, AW'(40'h55_51));
        press(B_ENTER);
        check("dial_valid", 64'(cmd_valid), 64'd1);
        check("dial_state", 64'(call_state), 64'(ST_INITIATE));
        check("dial_count_held", 64'(digit_count), 64'd4);
        check("dial_addr_early", 64'(cmd_addr), 64'h5551);
        press(B_LEFT);
        check("blocked_left_state", 64'(call_state), 64'(ST_INITIATE));
        check("hold_valid1", 64'(cmd_valid), 64'd1);
        cyc();
        check("hold_valid2", 64'(cmd_valid), 64'd1);
        cyc();
        check("hold_valid3", 64'(cmd_valid), 64'd1);
        check("hold_cmd", 64'(cmd), 64'(CMD_DIAL));
        cmd_ready = 1'b1;
        cyc();
        check("dial_released", 64'(cmd_valid), 64'd0);
        check("dial_buf_cleared", 64'(digit_count), 64'd0);

        // Answered call, menu SELECT in BUSY, call waiting and swap.
        net(N_ACC);
        check("accepted_busy", 64'(call_state), 64'(ST_BUSY));
        press(B_DOWN);
        check("busy_menu_down", 64'(menu_item), 64'd2);
        expect_cmd(CMD_SELECT, AW'(2));
        press(B_ENTER);
        check("busy_select_state", 64'(call_state), 64'(ST_BUSY));
        drain();
        net(N_INC);
        check("call_wait", 64'(call_state), 64'(ST_CALL_WAIT));
        expect_cmd(CMD_SWAP, '0);
        press(B_ENTER);
        check("swap_busy", 64'(call_state), 64'(ST_BUSY));
        drain();
        net(N_INC);
        check("call_wait2", 64'(call_state), 64'(ST_CALL_WAIT));
        net(N_HUP);
        check("wait_hangup_incoming", 64'(call_state), 64'(ST_INCOMING));

        // Network hangup beats a simultaneous reject press: no command.
        net_hangup = 1'b1;
        btn_left   = 1'b1;
        cyc();
        net_hangup = 1'b0;
        btn_left   = 1'b0;
        check("hangup_priority_state", 64'(call_state), 64'(ST_IDLE));
        cyc();
        check("hangup_priority_nocmd", 64'(cmd_valid), 64'd0);

        // Unanswered incoming call times out after RT cycles.
        expect_cmd(CMD_REJECT, '0);
        net(N_INC);
        check("incoming", 64'(call_state), 64'(ST_INCOMING));
        seen = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cmd_valid) begin
                seen = i;
                break;
            end
        end
        check("timeout_cycle", 64'(seen), 64'(RT));
        check("timeout_state", 64'(call_state), 64'(ST_IDLE));
        drain();

        // Block list: enter 42 on item 12, then that caller rings.
        press(B_UP);
        digit_in = 4'd4;
        press(B_RIGHT);
        digit_in = 4'd2;
        press(B_RIGHT);
        check("block_digits", 64'(digit_count), 64'd2);
        repeat (9) press(B_UP);
        check("menu_add_block", 64'(menu_item), 64'd12);
`ifdef CALL_BLOCK_EN
        press(B_ENTER);
        check("block_stored_clear", 64'(digit_count), 64'd0);
        check("block_no_cmd", 64'(cmd_valid), 64'd0);
        caller_addr = AW'(40'h42);
        expect_cmd(CMD_REJECT, '0);
        net(N_INC);
        check("blocked_stays_idle", 64'(call_state), 64'(ST_IDLE));
        drain();
`else
        expect_cmd(CMD_SELECT, AW'(12));
        press(B_ENTER);
        check("item12_keeps_digits", 64'(digit_count), 64'd2);
        drain();
        caller_addr = AW'(40'h42);
        net(N_INC);
        check("unblocked_incoming", 64'(call_state), 64'(ST_INCOMING));
        expect_cmd(CMD_REJECT, '0);
        press(B_LEFT);
        check("reject_idle", 64'(call_state), 64'(ST_IDLE));
        drain();
`endif
        caller_addr = AW'(40'h43);
        net(N_INC);
        check("other_caller_incoming", 64'(call_state), 64'(ST_INCOMING));
        expect_cmd(CMD_REJECT, '0);
        press(B_LEFT);
        check("other_reject_idle", 64'(call_state), 64'(ST_IDLE));
        drain();

        // Buffer saturates at NUM_DIGITS; dial the full number, then hang up.
        repeat (9) press(B_DOWN);
        check("menu_back3", 64'(menu_item), 64'd3);
        digit_in = 4'd9;
        repeat (12) press(B_RIGHT);
        check("count_full", 64'(digit_count), 64'(ND));
`ifdef CALL_BLOCK_EN
        expect_cmd(CMD_DIAL, AW'(40'h99_9999_9999));
`else
        expect_cmd(CMD_DIAL, AW'(40'h42_9999_9999));
`endif
        press(B_ENTER);
        check("full_dial_state", 64'(call_state), 64'(ST_INITIATE));
        drain();
        check("full_buf_cleared", 64'(digit_count), 64'd0);
        expect_cmd(CMD_HANGUP, '0);
        press(B_LEFT);
        check("hangup_idle", 64'(call_state), 64'(ST_IDLE));
        drain();

        repeat (3) cyc();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
